// File: rtl/fnd_pkg.sv
// Shared constants and the active-high 7-segment font for the FND scan controller.
package fnd_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark, active-high sense; polarity is applied at the pins.
    localparam logic [7:0] FONT_OFF = 8'h00;

    // {g,f,e,d,c,b,a}, 1 = segment lit; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] FONT_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] fnd_font(input logic [3:0] nibble);
        return FONT_TABLE[nibble];
    endfunction

endpackage

// File: rtl/fnd_scan_controller_font_lut.sv
// Combinational nibble to active-high segment decoder.
module fnd_font_lut
    import fnd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = fnd_font(nibble_i);

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed N-digit 7-segment driver with frame-coherent shadow registers,
// per-slot blanking, decimal points and leading-zero suppression.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_lzs,
    output logic [NUM_DIGITS-1:0]     o_digit,
    output logic [7:0]                o_font,
    output logic                      o_frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~FONT_OFF : FONT_OFF;

    logic [PW-1:0]             pres_q, pres_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0]     dp_q, dp_d;
    logic                      lzs_q, lzs_d;
    logic [NUM_DIGITS-1:0]     digit_q, digit_d;
    logic [7:0]                font_q, font_d;
    logic                      frame_done_q, frame_done_d;

    logic                      tick, wrap, blank, suppress;
    logic [NUM_DIGITS:0]       zero_from;
    logic [NUM_DIGITS-1:0]     sel;
    logic [3:0]                cur_nib;
    logic                      cur_dp, cur_zero;
    logic [6:0]                seg;
    logic [7:0]                font_on;

    fnd_font_lut u_font_lut (
        .nibble_i (cur_nib),
        .seg_o    (seg)
    );

    always_comb begin
        tick = i_en && (pres_q == PRE_MAX);
        wrap = tick && (idx_q == IDX_MAX);

        pres_d  = pres_q;
        idx_d   = idx_q;
        value_d = value_q;
        dp_d    = dp_q;
        lzs_d   = lzs_q;
        // While disabled the shadow tracks the inputs so re-enable shows fresh data.
        if (!i_en) begin
            pres_d  = '0;
            idx_d   = '0;
            value_d = i_value;
            dp_d    = i_dp;
            lzs_d   = i_lzs;
        end else begin
            pres_d = tick ? '0 : pres_q + PW'(1);
            if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
            if (wrap) begin
                value_d = i_value;
                dp_d    = i_dp;
                lzs_d   = i_lzs;
            end
        end
    end

    always_comb begin
        // zero_from[k]: every nibble from k up to the most significant is zero.
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            zero_from[k] = zero_from[k+1] && (value_q[4*k +: 4] == 4'h0);

        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        sel      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx_q) == k) begin
                cur_nib  = value_q[4*k +: 4];
                cur_dp   = dp_q[k];
                cur_zero = zero_from[k];
                sel[k]   = 1'b1;
            end
        end

        suppress = lzs_q && (idx_q != '0) && cur_zero;
        font_on                 = FONT_OFF;
        font_on[SEG_G:SEG_A]    = suppress ? 7'h00 : seg;
        font_on[SEG_DP]         = cur_dp;

        blank        = !i_en || (int'(pres_q) < BLANK_CYCLES);
        digit_d      = blank ? DIG_OFF : ((DIG_ACTIVE_LOW != 0) ? ~sel : sel);
        font_d       = blank ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? ~font_on : font_on);
        frame_done_d = wrap;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pres_q       <= '0;
            idx_q        <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            lzs_q        <= 1'b0;
            digit_q      <= DIG_OFF;
            font_q       <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pres_q       <= pres_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            lzs_q        <= lzs_d;
            digit_q      <= digit_d;
            font_q       <= font_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_digit      = digit_q;
    assign o_font       = font_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller (4 digits, 4 clocks/slot, 1 blank).
module tb_fnd_scan_controller;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] val = 16'h3210;
    logic [3:0]  dp = 4'h0;
    logic        lzs = 1'b0;
    logic [3:0]  dig;
    logic [7:0]  font;
    logic        fd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .NUM_DIGITS(ND), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_value(val),
        .i_dp(dp), .i_lzs(lzs), .o_digit(dig), .o_font(font), .o_frame_done(fd)
    );

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzs;
        logic [31:0] fonts;   // {digit3, digit2, digit1, digit0}, active-low
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sample n of a frame reflects state prescaler=(n-1)%4, idx=(n-1)/4.
    task automatic check_sample(input string tag, input int n, input logic [31:0] fonts);
        int slot;
        logic [3:0] exp_dig;
        slot = ((n - 1) % 16) / 4;
        if (((n - 1) % 4) == 0) begin
            chk({tag, " blank digit"}, {4'h0, dig}, 8'h0F);
            chk({tag, " blank font"}, font, 8'hFF);
        end else begin
            exp_dig = ~(4'b0001 << slot);
            chk({tag, " digit"}, {4'h0, dig}, {4'h0, exp_dig});
            chk({tag, " font"}, font, fonts[8*slot +: 8]);
        end
        chk({tag, " frame_done"}, {7'h0, fd}, {7'h0, (n % 16) == 0});
    endtask

    task automatic check_frame(input string tag, input logic [31:0] fonts);
        for (int n = 1; n <= 16; n++) begin
            step();
            check_sample(tag, n, fonts);
        end
    endtask

    // Disable for one edge so the shadow captures the inputs, then restart at digit 0.
    task automatic load_and_enable(input logic [15:0] v, input logic [3:0] d, input logic l);
        en  = 1'b0;
        val = v;
        dp  = d;
        lzs = l;
        step();
        en = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'h3210, 4'h0, 1'b0, 32'hB0A4F9C0};
        vecs[1] = '{16'hABCD, 4'h0, 1'b0, 32'h8883C6A1};
        vecs[2] = '{16'h0050, 4'h0, 1'b1, 32'hFFFF92C0};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, 32'hFFFFFFC0};
        vecs[4] = '{16'h0001, 4'b0010, 1'b0, 32'hC0C040F9};
        vecs[5] = '{16'h0001, 4'b0010, 1'b1, 32'hFFFF7FF9};
        vecs[6] = '{16'h0050, 4'h0, 1'b0, 32'hC0C092C0};
        vecs[7] = '{16'h1005, 4'h0, 1'b1, 32'hF9C0C092};
        vecs[8] = '{16'h8E76, 4'b1001, 1'b0, 32'h0086F802};
        vecs[9] = '{16'h49F0, 4'h0, 1'b1, 32'h99908EC0};

        // Asynchronous reset takes effect between clock edges.
        #1 rst_n = 1'b0;
        #1;
        chk("reset digit", {4'h0, dig}, 8'h0F);
        chk("reset font", font, 8'hFF);
        chk("reset frame_done", {7'h0, fd}, 8'h00);
        step();
        step();
        rst_n = 1'b1;

        // Shadow is zero out of reset; the first frame's wrap loads 3210.
        check_frame("post-reset", 32'hC0C0C0C0);
        check_frame("first load", 32'hB0A4F9C0);
        check_frame("steady", 32'hB0A4F9C0);

        for (int i = 0; i < 10; i++) begin
            load_and_enable(vecs[i].value, vecs[i].dp, vecs[i].lzs);
            check_frame($sformatf("vec%0d", i), vecs[i].fonts);
        end

        // Input change while digit 1 is lit stays hidden until the next frame.
        load_and_enable(16'h3210, 4'h0, 1'b0);
        for (int n = 1; n <= 32; n++) begin
            step();
            check_sample("midframe", n, (n <= 16) ? 32'hB0A4F9C0 : 32'h8883C6A1);
            if (n == 6) val = 16'hABCD;
        end

        // Drop enable while digit 2 is lit.
        load_and_enable(16'h3210, 4'h0, 1'b0);
        for (int n = 1; n <= 10; n++) step();
        chk("pre-drop digit", {4'h0, dig}, 8'h0B);
        chk("pre-drop font", font, 8'hA4);
        en  = 1'b0;
        val = 16'h5555;
        step();
        chk("disabled digit", {4'h0, dig}, 8'h0F);
        chk("disabled font", font, 8'hFF);
        chk("disabled frame_done", {7'h0, fd}, 8'h00);
        step();
        chk("disabled hold digit", {4'h0, dig}, 8'h0F);
        en = 1'b1;
        step();
        chk("reenable blank digit", {4'h0, dig}, 8'h0F);
        chk("reenable blank font", font, 8'hFF);
        step();
        chk("reenable digit0", {4'h0, dig}, 8'h0E);
        chk("reenable font", font, 8'h92);

        // Reset mid-frame goes dark at once and restarts at digit 0 with a cleared shadow.
        load_and_enable(16'h3210, 4'h0, 1'b0);
        for (int n = 1; n <= 7; n++) step();
        chk("pre-reset digit", {4'h0, dig}, 8'h0D);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset digit", {4'h0, dig}, 8'h0F);
        chk("midreset font", font, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("after midreset", 32'hC0C0C0C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
